// File: rtl/pa_fpbp_sequencer.sv
// pa_fpbp_sequencer: FP-then-BP element sequencer; do_fp/do_bp requests in, op_valid/op_ready/op_mode/op_idx issue, res_valid retire, acc_clr/done/protocol_err status out
module pa_fpbp_sequencer #(
  parameter int N_ELEM  = 784,
  parameter int IDX_W   = 10,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             do_fp,
  input  logic             do_bp,
  output logic             done_FP,
  output logic             done_BP,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             op_mode,
  output logic [IDX_W-1:0] op_idx,
  input  logic             res_valid,
  output logic             acc_clr,
  output logic             protocol_err
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] MAX = OW'(MAX_OUT);
  localparam logic [IDX_W:0] N = (IDX_W + 1)'(N_ELEM);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM - 1);
  typedef enum logic [2:0] {IDLE, FP_RUN, FP_DRAIN, FP_DONE, BP_RUN, BP_DRAIN, BP_DONE, ABORT} state_t;
  state_t state, state_nx;
  logic [OW-1:0] out, out_nx;
  logic [IDX_W:0] ret, ret_nx;
  logic [IDX_W-1:0] idx_nx;
  logic issue, dec, bad, clr, run_nx;
  always_comb begin
    issue = op_valid & op_ready;
    dec = res_valid & (out != '0);
    bad = res_valid & (out == '0 || ret == N);
    state_nx = state;
    case (state)
      IDLE:     state_nx = do_fp ? FP_RUN : IDLE;
      FP_RUN:   state_nx = !do_fp ? ABORT : (issue && op_idx == LAST) ? FP_DRAIN : FP_RUN;
      FP_DRAIN: state_nx = !do_fp ? ABORT : (out == '0 && ret == N) ? FP_DONE : FP_DRAIN;
      FP_DONE:  state_nx = do_bp ? BP_RUN : !do_fp ? IDLE : FP_DONE;
      BP_RUN:   state_nx = !do_bp ? ABORT : (issue && op_idx == LAST) ? BP_DRAIN : BP_RUN;
      BP_DRAIN: state_nx = !do_bp ? ABORT : (out == '0 && ret == N) ? BP_DONE : BP_DRAIN;
      BP_DONE:  state_nx = (!do_fp && !do_bp) ? IDLE : BP_DONE;
      ABORT:    state_nx = (out == '0) ? IDLE : ABORT;
      default:  state_nx = IDLE;
    endcase
    run_nx = state_nx == FP_RUN || state_nx == BP_RUN;
    clr = run_nx && state != FP_RUN && state != BP_RUN;
    out_nx = clr ? '0 : out + OW'(issue) - OW'(dec);
    ret_nx = clr ? '0 : ret + (IDX_W + 1)'(dec && ret != N);
    // index parks on the last element once it has been issued rather than wrapping
    idx_nx = clr ? '0 : op_idx + IDX_W'(issue && op_idx != LAST);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out <= '0;
      ret <= '0;
      op_idx <= '0;
      op_valid <= 1'b0;
      op_mode <= 1'b0;
      done_FP <= 1'b0;
      done_BP <= 1'b0;
      acc_clr <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nx;
      out <= out_nx;
      ret <= ret_nx;
      op_idx <= idx_nx;
      op_valid <= run_nx && out_nx < MAX;
      op_mode <= state_nx == BP_RUN ? 1'b1 : state_nx == FP_RUN ? 1'b0 : op_mode;
      done_FP <= state_nx inside {FP_DONE, BP_RUN, BP_DRAIN, BP_DONE};
      done_BP <= state_nx == BP_DONE;
      acc_clr <= state == FP_DONE && state_nx == BP_RUN;
      protocol_err <= protocol_err | bad;
    end
  end
endmodule

// File: tb/tb_pa_fpbp_sequencer.sv
// tb_pa_fpbp_sequencer: directed bench with a phase/count reference model checked every cycle
module tb_pa_fpbp_sequencer;
  localparam int N = 4;
  localparam int MX = 2;
  localparam int IW = 3;
  logic clk = 0, rst = 1, do_fp = 0, do_bp = 0, op_ready = 0, man_rv = 0, auto_rv = 0, pend;
  logic res_valid, done_FP, done_BP, op_valid, op_mode, acc_clr, protocol_err;
  logic [IW-1:0] op_idx;
  int checks = 0, errors = 0, acc_cnt = 0;
  bit saw_dfp = 0;
  int log_q[$];
  int t1_exp[8] = '{0, 1, 2, 3, 16, 17, 18, 19};
  pa_fpbp_sequencer #(.N_ELEM(N), .IDX_W(IW), .MAX_OUT(MX)) dut (
    .clk(clk), .rst(rst), .do_fp(do_fp), .do_bp(do_bp), .done_FP(done_FP), .done_BP(done_BP),
    .op_valid(op_valid), .op_ready(op_ready), .op_mode(op_mode), .op_idx(op_idx),
    .res_valid(res_valid), .acc_clr(acc_clr), .protocol_err(protocol_err));
  always #5 clk = ~clk;
  assign res_valid = auto_rv ? pend : man_rv;
  always @(posedge clk or posedge rst) pend <= rst ? 1'b0 : (op_valid && op_ready);
  always @(posedge clk) if (!rst && op_valid && op_ready) log_q.push_back(op_mode ? 16 + int'(op_idx) : int'(op_idx));
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, a, e, $time);
    end
  endtask
  // model: phase 0 idle, 1 fp active, 2 fp done, 3 bp active, 4 bp done, 5 abort
  int m_ph = 0, m_iss = 0, m_ret = 0, m_out = 0;
  bit m_mode = 0, m_acc = 0, m_err = 0, m_valid;
  always_comb m_valid = (m_ph == 1 || m_ph == 3) && m_iss < N && m_out < MX;
  always @(posedge clk or posedge rst) begin
    int ph;
    bit go, take, dec;
    if (rst) begin
      m_ph <= 0; m_iss <= 0; m_ret <= 0; m_out <= 0; m_mode <= 0; m_acc <= 0; m_err <= 0;
    end else begin
      ph = m_ph;
      go = 0;
      take = m_valid && op_ready;
      dec = res_valid && m_out > 0;
      m_acc <= 0;
      if (res_valid && (m_out == 0 || m_ret == N)) m_err <= 1;
      case (m_ph)
        0: if (do_fp) begin ph = 1; go = 1; m_mode <= 0; end
        1: if (!do_fp) ph = 5; else if (m_iss == N && m_out == 0 && m_ret == N) ph = 2;
        2: if (do_bp) begin ph = 3; go = 1; m_mode <= 1; m_acc <= 1; end else if (!do_fp) ph = 0;
        3: if (!do_bp) ph = 5; else if (m_iss == N && m_out == 0 && m_ret == N) ph = 4;
        4: if (!do_fp && !do_bp) ph = 0;
        default: if (m_out == 0) ph = 0;
      endcase
      m_ph <= ph;
      m_iss <= go ? 0 : m_iss + int'(take);
      m_out <= go ? 0 : m_out + int'(take) - int'(dec);
      m_ret <= go ? 0 : m_ret + int'(dec && m_ret < N);
    end
  end
  always @(negedge clk) begin
    chk("op_valid", 32'(op_valid), 32'(m_valid));
    chk("op_idx", 32'(op_idx), 32'(m_iss >= N ? N - 1 : m_iss));
    chk("op_mode", 32'(op_mode), 32'(m_mode));
    chk("done_FP", 32'(done_FP), 32'(m_ph >= 2 && m_ph <= 4));
    chk("done_BP", 32'(done_BP), 32'(m_ph == 4));
    chk("acc_clr", 32'(acc_clr), 32'(m_acc));
    chk("protocol_err", 32'(protocol_err), 32'(m_err));
    if (acc_clr) acc_cnt++;
    if (done_FP) saw_dfp = 1;
  end
  task automatic rst_pulse();
    rst = 1;
    @(negedge clk);
    rst = 0;
    log_q.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(op_valid), 0);
    chk("rst_idx", 32'(op_idx), 0);
    chk("rst_err", 32'(protocol_err), 0);
    rst = 0;
    // full FP then BP pass with auto-responding datapath
    do_fp = 1; do_bp = 1; op_ready = 1; auto_rv = 1;
    @(negedge clk);
    chk("t1_first_valid", 32'(op_valid), 1);
    chk("t1_first_idx", 32'(op_idx), 0);
    for (int i = 0; i < 80 && !done_BP; i++) @(negedge clk);
    chk("t1_done_bp", 32'(done_BP), 1);
    chk("t1_done_fp", 32'(done_FP), 1);
    chk("t1_acc_pulses", 32'(acc_cnt), 1);
    chk("t1_issue_count", 32'(log_q.size()), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) chk("t1_issue", 32'(log_q[i]), 32'(t1_exp[i]));
    do_fp = 0; do_bp = 0; auto_rv = 0;
    repeat (2) @(negedge clk);
    chk("t1_clr_fp", 32'(done_FP), 0);
    chk("t1_clr_bp", 32'(done_BP), 0);
    rst_pulse();
    // results withheld: MAX_OUT issues then stall
    do_fp = 1;
    repeat (6) @(negedge clk);
    chk("t2_issues", 32'(log_q.size()), 2);
    chk("t2_stalled", 32'(op_valid), 0);
    chk("t2_idx", 32'(op_idx), 2);
    man_rv = 1;
    @(negedge clk);
    man_rv = 0;
    chk("t2_resume_valid", 32'(op_valid), 1);
    chk("t2_resume_idx", 32'(op_idx), 2);
    @(negedge clk);
    chk("t2_third_issue", 32'(log_q.size() == 3 ? log_q[2] : -1), 2);
    do_fp = 0; op_ready = 0;
    rst_pulse();
    // op_ready backpressure holds the first operation
    do_fp = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(op_valid), 1);
      chk("t3_hold_idx", 32'(op_idx), 0);
    end
    chk("t3_no_issue", 32'(log_q.size()), 0);
    op_ready = 1;
    @(negedge clk);
    chk("t3_advance", 32'(op_idx), 1);
    do_fp = 0; op_ready = 0;
    rst_pulse();
    // abort after two issues, drain, back to idle
    saw_dfp = 0;
    do_fp = 1; op_ready = 1;
    repeat (4) @(negedge clk);
    chk("t4_issues", 32'(log_q.size()), 2);
    do_fp = 0;
    @(negedge clk);
    man_rv = 1; @(negedge clk); man_rv = 0; @(negedge clk);
    man_rv = 1; @(negedge clk); man_rv = 0;
    repeat (3) @(negedge clk);
    chk("t4_no_done", 32'(saw_dfp), 0);
    chk("t4_err", 32'(protocol_err), 0);
    chk("t4_valid", 32'(op_valid), 0);
    do_fp = 1;
    @(negedge clk);
    chk("t4_restart_valid", 32'(op_valid), 1);
    chk("t4_restart_idx", 32'(op_idx), 0);
    do_fp = 0; op_ready = 0;
    repeat (3) @(negedge clk);
    // spurious result in idle is sticky
    man_rv = 1;
    @(negedge clk);
    man_rv = 0;
    chk("t5_err_set", 32'(protocol_err), 1);
    repeat (5) @(negedge clk);
    chk("t5_err_held", 32'(protocol_err), 1);
    rst_pulse();
    chk("t5_err_rst", 32'(protocol_err), 0);
    // reset during BP_RUN
    do_fp = 1; do_bp = 1; op_ready = 1; auto_rv = 1;
    for (int i = 0; i < 60 && !(op_mode && op_valid); i++) @(negedge clk);
    chk("t6_in_bp", 32'(op_mode && op_valid), 1);
    #2 rst = 1;
    #1;
    chk("t6_async", 32'({op_valid, done_FP, done_BP, acc_clr, protocol_err, op_mode, op_idx}), 0);
    @(negedge clk);
    rst = 0; do_bp = 0; auto_rv = 0;
    log_q.delete();
    @(negedge clk);
    chk("t6_restart_valid", 32'(op_valid), 1);
    chk("t6_restart_idx", 32'(op_idx), 0);
    chk("t6_restart_mode", 32'(op_mode), 0);
    man_rv = 1;
    @(negedge clk);
    man_rv = 0;
    chk("t6_late_res_err", 32'(protocol_err), 1);
    do_fp = 0; op_ready = 0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pa_fpbp_sequencer.md
PA_FPBP_SEQUENCER -- requirements
Module: pa_fpbp_sequencer

Interface
REQ-001 The block SHALL have parameter N_ELEM, default 784, giving the number of elements per channel pass.
REQ-002 The block SHALL have parameter IDX_W, default 10, giving the element index width; N_ELEM SHALL be at most 2^IDX_W.
REQ-003 The block SHALL have parameter MAX_OUT, default 4, giving the maximum number of issued-but-unretired operations.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 do_fp  input  1  forward-pass request level from the initiator.
REQ-007 do_bp  input  1  backward-pass request level from the initiator.
REQ-008 done_FP  output  1  forward pass complete, level.
REQ-009 done_BP  output  1  backward pass complete, level.
REQ-010 op_valid  output  1  operation issue request to the FP32 datapath.
REQ-011 op_ready  input  1  datapath accepts the operation.
REQ-012 op_mode  output  1  0 = FP (z = w*fmap+b), 1 = BP (deriv, delta error, weight/bias accumulate).
REQ-013 op_idx  output  IDX_W  element index of the current operation.
REQ-014 res_valid  input  1  one-cycle pulse per retired operation from the datapath.
REQ-015 acc_clr  output  1  one-cycle pulse clearing the datapath weight/bias accumulators.
REQ-016 protocol_err  output  1  sticky error flag.

Function
REQ-017 FSM states SHALL be IDLE, FP_RUN, FP_DRAIN, FP_DONE, BP_RUN, BP_DRAIN, BP_DONE and ABORT.
REQ-018 An issue SHALL occur only when op_valid and op_ready are both high in the same cycle.
REQ-019 op_valid SHALL be high only in FP_RUN or BP_RUN, and only while the outstanding count is below MAX_OUT.
REQ-020 op_idx and op_mode SHALL hold stable while op_valid is high and op_ready is low.
REQ-021 IDLE -> FP_RUN SHALL occur when do_fp is high, clearing the issue counter, retire counter and outstanding counter; first op_valid SHALL appear the cycle after the transition, with op_idx=0 and op_mode=0.
REQ-022 op_idx SHALL increment by 1 per issue.
REQ-023 After the issue with op_idx = N_ELEM-1, the FSM SHALL go FP_RUN -> FP_DRAIN and op_valid SHALL drop the next cycle (no wrap to 0).
REQ-024 Outstanding count: increment on issue, decrement on res_valid, unchanged when both occur in the same cycle; width SHALL be clog2(MAX_OUT+1).
REQ-025 FP_DRAIN -> FP_DONE SHALL occur when outstanding = 0 and retire count = N_ELEM; done_FP SHALL rise the cycle after that condition is met.
REQ-026 FP_DONE -> BP_RUN SHALL occur when do_bp is high; acc_clr SHALL pulse for exactly one cycle on BP_RUN entry; counters SHALL be cleared; op_mode=1.
REQ-027 BP_RUN, BP_DRAIN and BP_DONE SHALL mirror REQ-022 to REQ-025, with done_BP rising in BP_DONE; done_FP SHALL remain high throughout BP.
REQ-028 FP_DONE/BP_DONE -> IDLE SHALL occur when do_fp and do_bp are both low; done_FP and done_BP SHALL clear on entering IDLE.
REQ-029 If do_bp is high in IDLE without do_fp, the block SHALL stay in IDLE (BP requires prior FP).
REQ-030 Deasserting do_fp in FP_RUN/FP_DRAIN, or do_bp in BP_RUN/BP_DRAIN, SHALL cause a transition to ABORT: no issues, wait for outstanding = 0, then go to IDLE with no done asserted.
REQ-031 res_valid with outstanding = 0, or with retire count already equal to N_ELEM, SHALL set protocol_err; the outstanding count SHALL saturate at 0.
REQ-032 protocol_err SHALL clear only on rst.

Reset
REQ-033 On rst the FSM SHALL go to IDLE and all counters SHALL go to 0; done_FP, done_BP, op_valid, acc_clr, protocol_err, op_mode and op_idx SHALL all be 0, asynchronously.
REQ-034 Reset mid-operation SHALL abandon in-flight operations; late res_valid pulses after reset release SHALL set protocol_err.

Verification (N_ELEM=4, MAX_OUT=2)
REQ-035 Check: do_fp=do_bp=1, op_ready=1, res_valid one cycle after each issue -> idx 0..3 mode 0, done_FP, one acc_clr pulse, idx 0..3 mode 1, done_BP; drop both requests -> IDLE, dones clear.
REQ-036 Check: res_valid withheld -> exactly 2 issues (idx 0,1) then op_valid low; one res_valid -> issue idx 2 next cycle.
REQ-037 Check: op_ready low for 3 cycles with op_valid high -> op_idx stays 0, no counter change.
REQ-038 Check: do_fp dropped after 2 issues -> ABORT; after 2 res_valid -> IDLE, done_FP never high, protocol_err=0.
REQ-039 Check: spurious res_valid in IDLE -> protocol_err=1, held until rst.
REQ-040 Check: rst asserted in BP_RUN -> all outputs 0 immediately; next do_fp restarts at idx 0, mode 0.
